// File: rtl/regfile_dump.sv
// Debug dump engine: walks an inclusive, wrapping register range through a
// dedicated combinational read port and streams (addr, data) over valid/ready.
module regfile_dump #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] lo_addr,
    input  logic [ADDR_W-1:0] hi_addr,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_SEND
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_hi;
    logic              r_out_valid;
    logic [ADDR_W-1:0] r_out_addr;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_last;
    logic              r_done;
    logic              w_handshake;
    logic [ADDR_W-1:0] w_cnt_inc;

    assign w_handshake = r_out_valid & out_ready;
    // Wrap at NUM_REGS rather than relying on ADDR_W overflow alone.
    assign w_cnt_inc   = (r_cnt == ADDR_W'(NUM_REGS - 1)) ? '0 : r_cnt + 1'b1;

    // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_READ;
            S_READ:  w_state_nxt = S_SEND;
            S_SEND:  if (w_handshake) w_state_nxt = r_out_last ? S_IDLE : S_READ;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_hi        <= '0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt <= lo_addr;
                        r_hi  <= hi_addr;
                    end
                end
                S_READ: begin
                    // Snapshot taken here; later register-file writes do not affect this word.
                    r_out_data  <= rf_data;
                    r_out_addr  <= r_cnt;
                    r_out_valid <= 1'b1;
                    r_out_last  <= (r_cnt == r_hi);
                end
                S_SEND: begin
                    if (w_handshake) begin
                        r_out_valid <= 1'b0;
                        if (r_out_last) r_done <= 1'b1;
                        else            r_cnt  <= w_cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rf_addr   = r_cnt;
    assign out_valid = r_out_valid;
    assign out_addr  = r_out_addr;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;

endmodule
